// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - streams bitstream words serially into a configuration flip-flop chain
//
// Purpose: accepts WORD_W-bit words through a one-word holding register and
// shifts them MSB first onto ccff_head, qualifying each bit with shift_en.
// Exactly BITSTREAM_SIZE bits are shifted per run, and the surplus LSBs of
// the final word are dropped.
//
// Optional feature macro: CCFF_LOADER_TAIL_CHECK_EN. When defined, the first
// bit shifted is compared with ccff_tail one cycle after the final shift.
// A mismatch or an unknown value sets the sticky error flag.
//
// Ports:
//   prog_clk    single clock, rising edge
//   pReset      asynchronous active-low reset
//   start       one-cycle run request, honoured only in IDLE
//   abort       cancel the current run
//   word_data   bitstream word, MSB shifted first
//   word_valid  word_data valid
//   word_ready  loader takes a word this cycle
//   ccff_head   serial bit to the chain head (registered)
//   shift_en    chain clock-gate enable, high only while ccff_head is a valid bit
//   ccff_tail   chain tail, used only by the tail check
//   busy        run in progress
//   done        one-cycle completion pulse
//   error       sticky tail-check failure
//   bit_count   bits shifted in the current or most recent run
module ccff_loader #(
  parameter int BITSTREAM_SIZE = 29696,
  parameter int WORD_W         = 32
) (
  input  logic                              prog_clk,
  input  logic                              pReset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [WORD_W-1:0]                 word_data,
  input  logic                              word_valid,
  output logic                              word_ready,
  output logic                              ccff_head,
  output logic                              shift_en,
  input  logic                              ccff_tail,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [$clog2(BITSTREAM_SIZE+1)-1:0] bit_count
);

  localparam int CNT_W  = $clog2(BITSTREAM_SIZE + 1);
  localparam int NWORDS = (BITSTREAM_SIZE + WORD_W - 1) / WORD_W;
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam int BITS_W = $clog2(WORD_W + 1);
  localparam int REM    = BITSTREAM_SIZE % WORD_W;

  localparam logic [BITS_W-1:0] FULL_BITS = BITS_W'(WORD_W);
  localparam logic [BITS_W-1:0] LAST_BITS = (REM != 0) ? BITS_W'(REM) : BITS_W'(WORD_W);
  localparam logic [CNT_W-1:0]  TOTAL     = CNT_W'(BITSTREAM_SIZE);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
  localparam logic [WCNT_W-1:0] ALL_WORDS = WCNT_W'(NWORDS);

  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, CHECK, DONE} state_t;

  state_t               state_q, state_d;
  logic [WORD_W-1:0]    hold_q;
  logic                 hold_full;
  logic [BITS_W-1:0]    hold_bits;   // bits the held word contributes (short for the last word)
  logic [WORD_W-1:0]    sreg;
  logic [BITS_W-1:0]    sreg_cnt;    // bits still to shift out of sreg
  logic [WCNT_W-1:0]    words_acc;

  logic active, accept, do_shift, next_bit;

  assign active     = (state_q == FETCH) || (state_q == SHIFT);
  // Gated with abort so a simultaneous handshake is refused, not silently lost.
  assign word_ready = active && !abort && !hold_full && (words_acc != ALL_WORDS);
  assign accept     = word_valid && word_ready;
  assign do_shift   = (state_q == SHIFT) && !abort && (bit_count != TOTAL) &&
                      ((sreg_cnt != '0) || hold_full);
  // An empty sreg takes its first bit straight from the holding register, so
  // the first bit appears two cycles after the handshake.
  assign next_bit   = (sreg_cnt != '0) ? sreg[WORD_W-1] : hold_q[WORD_W-1];
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: if (accept) state_d = SHIFT;
      SHIFT: begin
        // The last bit is on ccff_head in the cycle bit_count reaches TOTAL.
        if (bit_count == TOTAL) begin
`ifdef CCFF_LOADER_TAIL_CHECK_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
      CHECK: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
      hold_bits <= '0;
      sreg      <= '0;
      sreg_cnt  <= '0;
      words_acc <= '0;
      ccff_head <= 1'b0;
      shift_en  <= 1'b0;
      bit_count <= '0;
    end else begin
      shift_en <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          bit_count <= '0;
          hold_full <= 1'b0;
          sreg_cnt  <= '0;
          words_acc <= '0;
        end
      end else if (abort) begin
        hold_full <= 1'b0;
        sreg_cnt  <= '0;
      end else begin
        if (accept) begin
          hold_q    <= word_data;
          hold_full <= 1'b1;
          hold_bits <= (words_acc == LAST_WORD) ? LAST_BITS : FULL_BITS;
          words_acc <= words_acc + 1'b1;
        end
        if (do_shift) begin
          ccff_head <= next_bit;
          shift_en  <= 1'b1;
          bit_count <= bit_count + 1'b1;
          if (sreg_cnt != '0) begin
            if ((sreg_cnt == BITS_W'(1)) && hold_full) begin
              // Reload as the last bit leaves, keeping the stream gap-free.
              sreg      <= hold_q;
              sreg_cnt  <= hold_bits;
              hold_full <= 1'b0;
            end else begin
              sreg     <= sreg << 1;
              sreg_cnt <= sreg_cnt - 1'b1;
            end
          end else begin
            sreg      <= hold_q << 1;
            sreg_cnt  <= hold_bits - 1'b1;
            hold_full <= 1'b0;
          end
        end
      end
    end
  end

`ifdef CCFF_LOADER_TAIL_CHECK_EN
  logic first_bit;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      first_bit <= 1'b0;
      error     <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start) error <= 1'b0;
      if (do_shift && (bit_count == '0)) first_bit <= next_bit;
      if ((state_q == CHECK) && !abort) begin
        // An unknown tail makes the equality unknown, which takes the else arm.
        if (ccff_tail == first_bit) error <= error;
        else                        error <= 1'b1;
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - scoreboard bench for ccff_loader (64-bit and 40-bit instances)
module tb_ccff_loader;

  logic        prog_clk, pReset, start, abort, word_valid;
  logic [31:0] word_data;
  logic        word_ready64, ccff_head64, shift_en64, ccff_tail64, busy64, done64, error64;
  logic [6:0]  bit_count64;
  logic        word_ready40, ccff_head40, shift_en40, ccff_tail40, busy40, done40, error40;
  logic [5:0]  bit_count40;

  logic [63:0] chain64 = '0;
  logic [39:0] chain40 = '0;
  logic        tail_force;
  logic        extra_mode;
  int          extra_acc = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic q0[$];
  logic q1[$];
  int   dq0[$];
  int   dq1[$];
  int   latq0[$];
  int   latq1[$];
  logic last_exp[2];
  logic prev_done[2];
  logic first_pending[2];
  logic seen[2];
  int   cur_gap[2];
  int   max_gap[2];

  ccff_loader #(.BITSTREAM_SIZE(64), .WORD_W(32)) dut64 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready64),
    .ccff_head(ccff_head64), .shift_en(shift_en64), .ccff_tail(ccff_tail64),
    .busy(busy64), .done(done64), .error(error64), .bit_count(bit_count64)
  );

  ccff_loader #(.BITSTREAM_SIZE(40), .WORD_W(32)) dut40 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready40),
    .ccff_head(ccff_head40), .shift_en(shift_en40), .ccff_tail(ccff_tail40),
    .busy(busy40), .done(done40), .error(error40), .bit_count(bit_count40)
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  always @(posedge prog_clk) cyc <= cyc + 1;

  // Chain models: after N gated shifts the tail holds the first bit shifted.
  always @(posedge prog_clk) begin
    if (shift_en64) chain64 <= {chain64[62:0], ccff_head64};
    if (shift_en40) chain40 <= {chain40[38:0], ccff_head40};
  end
  assign ccff_tail64 = tail_force ? 1'b0 : chain64[63];
  assign ccff_tail40 = tail_force ? 1'b0 : chain40[39];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mon_step(input int i);
    logic sh, hd, dn, bz, e;
    logic [6:0] bc;
    int d, lc;
    sh = (i == 0) ? shift_en64 : shift_en40;
    hd = (i == 0) ? ccff_head64 : ccff_head40;
    dn = (i == 0) ? done64 : done40;
    bz = (i == 0) ? busy64 : busy40;
    bc = (i == 0) ? bit_count64 : {1'b0, bit_count40};
    if (!pReset) begin
      last_exp[i] = 1'b0;
      prev_done[i] = 1'b0;
      first_pending[i] = 1'b0;
      return;
    end
    if (start && !busy64) begin
      first_pending[i] = 1'b1;
      cur_gap[i] = 0;
      max_gap[i] = 0;
      seen[i] = 1'b0;
    end
    if (sh) begin
      if (((i == 0) ? q0.size() : q1.size()) == 0) begin
        total++; bad++;
        $display("FAIL dut%0d_unexpected_shift: got shift_en=1 want no pending bit", i);
      end else begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("dut%0d_head_bit", i), hd, e);
        last_exp[i] = e;
      end
      if (first_pending[i]) begin
        first_pending[i] = 1'b0;
        if (((i == 0) ? latq0.size() : latq1.size()) == 0) begin
          total++; bad++;
          $display("FAIL dut%0d_first_latency: got shift at cycle %0d want none", i, cyc);
        end else begin
          if (i == 0) lc = latq0.pop_front();
          else        lc = latq1.pop_front();
          chk($sformatf("dut%0d_first_latency", i), cyc, lc);
        end
      end
      if (seen[i] && (cur_gap[i] > max_gap[i])) max_gap[i] = cur_gap[i];
      cur_gap[i] = 0;
      seen[i] = 1'b1;
    end else begin
      chk($sformatf("dut%0d_head_held", i), hd, last_exp[i]);
      if (seen[i]) cur_gap[i]++;
    end
    if (dn) begin
      if (prev_done[i]) begin
        total++; bad++;
        $display("FAIL dut%0d_done_width: got done high 2 cycles want 1", i);
      end
      chk($sformatf("dut%0d_done_busy", i), bz, 0);
      if (((i == 0) ? dq0.size() : dq1.size()) == 0) begin
        total++; bad++;
        $display("FAIL dut%0d_unexpected_done: got done=1 want 0", i);
      end else begin
        if (i == 0) d = dq0.pop_front();
        else        d = dq1.pop_front();
        chk($sformatf("dut%0d_done_count", i), bc, d);
      end
    end
    prev_done[i] = dn;
  endtask

  always @(negedge prog_clk) begin
    if (extra_mode && word_valid && (word_ready64 || word_ready40)) extra_acc++;
    for (int i = 0; i < 2; i++) mon_step(i);
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_head64"}, ccff_head64, 0);   chk({tag, "_head40"}, ccff_head40, 0);
    chk({tag, "_shen64"}, shift_en64, 0);    chk({tag, "_shen40"}, shift_en40, 0);
    chk({tag, "_ready64"}, word_ready64, 0); chk({tag, "_ready40"}, word_ready40, 0);
    chk({tag, "_busy64"}, busy64, 0);        chk({tag, "_busy40"}, busy40, 0);
    chk({tag, "_done64"}, done64, 0);        chk({tag, "_done40"}, done40, 0);
    chk({tag, "_err64"}, error64, 0);        chk({tag, "_err40"}, error40, 0);
    chk({tag, "_cnt64"}, bit_count64, 0);    chk({tag, "_cnt40"}, bit_count40, 0);
  endtask

  task automatic send_word(input logic [31:0] w, input int k);
    bit ok;
    int n40;
    ok = 1'b0;
    word_data = w;
    word_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge prog_clk);
      if (word_ready64 && word_ready40) ok = 1'b1;
      @(posedge prog_clk); #1;
      if (ok) break;
    end
    word_valid = 1'b0;
    chk("word_accept", ok, 1);
    if (ok) begin
      for (int b = 31; b >= 0; b--) q0.push_back(w[b]);
      n40 = (k == 0) ? 32 : 8;
      for (int b = 0; b < n40; b++) q1.push_back(w[31-b]);
      if (k == 0) begin
        latq0.push_back(cyc + 1);
        latq1.push_back(cyc + 1);
      end
    end
  endtask

  // stop_kind 0 aborts at stop_at bits, 1 asserts reset at stop_at bits.
  task automatic run(input logic [31:0] w0, input logic [31:0] w1, input int gap,
                     input int stop_at, input int stop_kind, input bit extra,
                     input bit poke_start, input bit exp_err);
    bit ok;
    int ea;
    @(posedge prog_clk); #1;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    chk("start_busy64", busy64, 1);     chk("start_busy40", busy40, 1);
    chk("start_cnt64", bit_count64, 0); chk("start_cnt40", bit_count40, 0);
    chk("start_err64", error64, 0);     chk("start_err40", error40, 0);
    if (stop_at == 0) begin
      dq0.push_back(64);
      dq1.push_back(40);
    end
    send_word(w0, 0);
    if (gap > 0) begin
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        if (bit_count64 == 7'd32) begin ok = 1'b1; break; end
        @(posedge prog_clk); #1;
      end
      chk("reach_bit32", ok, 1);
      repeat (gap) @(posedge prog_clk);
      #1;
    end
    send_word(w1, 1);
    if (poke_start) begin
      start = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0;
    end
    ea = extra_acc;
    if (extra) begin
      word_data = 32'hDEADBEEF;
      word_valid = 1'b1;
      extra_mode = 1'b1;
    end
    if (stop_at > 0) begin
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
        if (bit_count64 == 7'(stop_at)) begin ok = 1'b1; break; end
        @(posedge prog_clk); #1;
      end
      chk("reach_stop", ok, 1);
      if (stop_kind == 0) begin
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        chk("abort_busy64", busy64, 0);      chk("abort_busy40", busy40, 0);
        chk("abort_shen64", shift_en64, 0);  chk("abort_shen40", shift_en40, 0);
        chk("abort_ready64", word_ready64, 0);
        chk("abort_cnt64", bit_count64, stop_at); chk("abort_cnt40", bit_count40, stop_at);
        chk("abort_done64", done64, 0);
        q0.delete();
        q1.delete();
        repeat (6) @(posedge prog_clk);
        #1;
        chk("abort_idle_busy64", busy64, 0);
        chk("abort_idle_cnt64", bit_count64, stop_at);
      end else begin
        #1 pReset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q0.delete();
        q1.delete();
        repeat (3) @(posedge prog_clk);
        #2 pReset = 1'b1;
        repeat (4) @(posedge prog_clk);
        #1;
        chk("postrst_busy64", busy64, 0);
        chk("postrst_cnt64", bit_count64, 0);
      end
    end else begin
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
        @(negedge prog_clk);
        if (done64) begin ok = 1'b1; break; end
      end
      chk("done_seen", ok, 1);
      @(posedge prog_clk); #1;
      word_valid = 1'b0;
      extra_mode = 1'b0;
      chk("end_busy64", busy64, 0);       chk("end_busy40", busy40, 0);
      chk("end_done64", done64, 0);
      chk("end_cnt64", bit_count64, 64);  chk("end_cnt40", bit_count40, 40);
      chk("end_err64", error64, exp_err); chk("end_err40", error40, exp_err);
      chk("end_ready64", word_ready64, 0);
      chk("bits_left64", q0.size(), 0);   chk("bits_left40", q1.size(), 0);
      chk("dones_left", dq0.size() + dq1.size(), 0);
      chk("lat_left", latq0.size() + latq1.size(), 0);
      chk("extra_word_accepts", extra_acc - ea, 0);
      if (gap > 0) begin
        chk("gap64_ge4", max_gap[0] >= 4, 1);
        chk("gap40_ge4", max_gap[1] >= 4, 1);
      end
    end
  endtask

  initial begin
    pReset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    word_valid = 1'b0;
    word_data = '0;
    tail_force = 1'b0;
    extra_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last_exp[i] = 1'b0; prev_done[i] = 1'b0; first_pending[i] = 1'b0;
      seen[i] = 1'b0; cur_gap[i] = 0; max_gap[i] = 0;
    end
    #1 pReset = 1'b0;
    #1;
    check_reset_outputs("por");
    #20 pReset = 1'b1;
    repeat (3) @(posedge prog_clk);

    run(32'h80000000, 32'h00000000, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run(32'h80000000, 32'h00000000, 5, 0, 0, 1'b0, 1'b0, 1'b0);
    run(32'hFFFFFFFF, 32'hAB000000, 0, 0, 0, 1'b1, 1'b0, 1'b0);
`ifdef CCFF_LOADER_TAIL_CHECK_EN
    tail_force = 1'b1;
    run(32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    tail_force = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("err_sticky64", error64, 1);
    chk("err_sticky40", error40, 1);
`endif
    run(32'h12345678, 32'h9ABCDEF0, 0, 20, 0, 1'b0, 1'b0, 1'b0);
    run(32'hA5A5A5A5, 32'h0F0F0F0F, 0, 30, 1, 1'b0, 1'b0, 1'b0);
    run(32'hC3C3C3C3, 32'h3C3C3C3C, 0, 0, 0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 want finish");
    $fatal(1);
  end

endmodule
